// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the unified block RAM.
// The slave modport is the arbiter's view; the master modport is the CPU/RAM side.
interface mem_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i;
    logic [31:0] dm_addr_i;
    logic [3:0]  dm_write_mask_i;
    logic [31:0] dm_write_data_i;
    logic        dm_gnt_o;
    logic        dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        mem_en_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_write_mask_o;
    logic [31:0] mem_write_data_o;
    logic [31:0] mem_read_data_i;
    logic [31:0] contention_count_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_req_i, dm_addr_i, dm_write_mask_i, dm_write_data_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_en_o, mem_addr_o, mem_write_mask_o, mem_write_data_o,
        input  mem_read_data_i,
        output contention_count_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_req_i, dm_addr_i, dm_write_mask_i, dm_write_data_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_en_o, mem_addr_o, mem_write_mask_o, mem_write_data_o,
        output mem_read_data_i,
        input  contention_count_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port synchronous-read RAM: data first, fetch forced after a bounded data streak.
// Optional MEM_ARB_PERF_EN adds a 32-bit counter of cycles where both ports request.
module mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DM   = 2'd2
    } rsp_e;

    localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_DATA_STREAK);

    rsp_e       r_rsp;
    rsp_e       w_rsp_nxt;
    logic [3:0] r_streak;
    logic [3:0] w_streak_nxt;
    logic       w_if_gnt;
    logic       w_dm_gnt;

    // Grants are gated by reset so nothing reaches the RAM while reset is held.
    always_comb begin
        w_dm_gnt = 1'b0;
        w_if_gnt = 1'b0;
        if (reset_i) begin
            if (bus.dm_req_i && !(bus.if_req_i && (r_streak == LP_MAX_STREAK))) begin
                w_dm_gnt = 1'b1;
            end else if (bus.if_req_i) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    assign bus.if_gnt_o = w_if_gnt;
    assign bus.dm_gnt_o = w_dm_gnt;

    always_comb begin
        w_streak_nxt = r_streak;
        if (!bus.if_req_i || w_if_gnt) begin
            w_streak_nxt = 4'd0;
        end else if (w_dm_gnt) begin
            w_streak_nxt = (r_streak >= LP_MAX_STREAK) ? LP_MAX_STREAK : r_streak + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_streak <= 4'd0;
        end else begin
            r_streak <= w_streak_nxt;
        end
    end

    always_comb begin
        bus.mem_en_o         = w_if_gnt | w_dm_gnt;
        bus.mem_addr_o       = 32'd0;
        bus.mem_write_mask_o = 4'd0;
        bus.mem_write_data_o = 32'd0;
        if (w_dm_gnt) begin
            bus.mem_addr_o       = bus.dm_addr_i;
            bus.mem_write_mask_o = bus.dm_write_mask_i;
            bus.mem_write_data_o = bus.dm_write_data_i;
        end else if (w_if_gnt) begin
            bus.mem_addr_o = bus.if_addr_i;
        end
    end

    // Response owner: records who issued the read whose data the RAM returns next cycle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rsp <= RSP_NONE;
        end else begin
            r_rsp <= w_rsp_nxt;
        end
    end

    always_comb begin
        w_rsp_nxt = RSP_NONE;
        if (w_if_gnt) begin
            w_rsp_nxt = RSP_IF;
        end else if (w_dm_gnt && (bus.dm_write_mask_i == 4'd0)) begin
            w_rsp_nxt = RSP_DM;
        end

        bus.if_rvalid_o = 1'b0;
        bus.if_rdata_o  = 32'd0;
        bus.dm_rvalid_o = 1'b0;
        bus.dm_rdata_o  = 32'd0;
        case (r_rsp)
            RSP_IF: begin
                bus.if_rvalid_o = 1'b1;
                bus.if_rdata_o  = bus.mem_read_data_i;
            end
            RSP_DM: begin
                bus.dm_rvalid_o = 1'b1;
                bus.dm_rdata_o  = bus.mem_read_data_i;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_contention;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_contention <= 32'd0;
        end else if (bus.if_req_i && bus.dm_req_i) begin
            r_contention <= r_contention + 32'd1;
        end
    end

    assign bus.contention_count_o = r_contention;
`else
    assign bus.contention_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then constrained-random traffic against a rule-level model and a behavioural RAM.
module tb_mem_arbiter;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
        .clk_i  (clk),
        .reset_i(rst_n),
        .bus    (bus)
    );

    // Behavioural RAM: unwritten words hold their own byte address; write-first read.
    logic [31:0] ram     [0:255];
    bit          written [0:255];
    logic [31:0] env_w;

    function automatic logic [31:0] rd_word(input logic [31:0] addr);
        return written[addr[9:2]] ? ram[addr[9:2]] : {22'd0, addr[9:2], 2'b00};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            env_w = rd_word(bus.mem_addr_o);
            for (int b = 0; b < 4; b++)
                if (bus.mem_write_mask_o[b]) env_w[8*b +: 8] = bus.mem_write_data_o[8*b +: 8];
            ram[bus.mem_addr_o[9:2]]     <= env_w;
            written[bus.mem_addr_o[9:2]] <= 1'b1;
            bus.mem_read_data_i          <= env_w;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state, expressed in terms of the arbitration rules.
    int          m_data_run = 0;   // data grants in a row while fetch has been waiting
    int          m_owner    = 0;   // 0 none, 1 fetch, 2 data: who receives data this cycle
    logic [31:0] m_odata    = '0;
    logic [31:0] m_cnt      = '0;
    int          fetch_gnts = 0;

    logic        obs_if_g, obs_dm_g, obs_if_rv, obs_dm_rv;
    logic [31:0] obs_if_rd, obs_dm_rd, obs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        eg_if, eg_dm;
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_mask;
        @(negedge clk);
        eg_if = 1'b0;
        eg_dm = 1'b0;
        if (!rst_n) begin
            m_data_run = 0;
            m_owner    = 0;
            m_cnt      = '0;
        end else begin
            eg_dm = bus.dm_req_i && !(bus.if_req_i && m_data_run == MAXS);
            eg_if = bus.if_req_i && !eg_dm;
        end
        e_addr = eg_dm ? bus.dm_addr_i : (eg_if ? bus.if_addr_i : 32'd0);
        e_mask = eg_dm ? bus.dm_write_mask_i : 4'd0;
        e_data = eg_dm ? bus.dm_write_data_i : 32'd0;

        obs_if_g  = bus.if_gnt_o;
        obs_dm_g  = bus.dm_gnt_o;
        obs_if_rv = bus.if_rvalid_o;
        obs_dm_rv = bus.dm_rvalid_o;
        obs_if_rd = bus.if_rdata_o;
        obs_dm_rd = bus.dm_rdata_o;
        obs_cnt   = bus.contention_count_o;

        chk("if_gnt", 32'(obs_if_g), 32'(eg_if));
        chk("dm_gnt", 32'(obs_dm_g), 32'(eg_dm));
        chk("mem_en", 32'(bus.mem_en_o), 32'(eg_if | eg_dm));
        chk("mem_addr", bus.mem_addr_o, e_addr);
        chk("mem_mask", 32'(bus.mem_write_mask_o), 32'(e_mask));
        chk("mem_wdata", bus.mem_write_data_o, e_data);
        chk("if_rvalid", 32'(obs_if_rv), 32'(m_owner == 1));
        chk("if_rdata", obs_if_rd, (m_owner == 1) ? m_odata : 32'd0);
        chk("dm_rvalid", 32'(obs_dm_rv), 32'(m_owner == 2));
        chk("dm_rdata", obs_dm_rd, (m_owner == 2) ? m_odata : 32'd0);
`ifdef MEM_ARB_PERF_EN
        chk("contention", obs_cnt, m_cnt);
`else
        chk("contention", obs_cnt, 32'd0);
`endif

        if (rst_n) begin
            if (eg_if) fetch_gnts++;
            m_owner = eg_if ? 1 : ((eg_dm && e_mask == 4'd0) ? 2 : 0);
            m_odata = rd_word(e_addr);
            m_data_run = (!bus.if_req_i || eg_if) ? 0 : m_data_run + 1;
            if (bus.if_req_i && bus.dm_req_i) m_cnt = m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic [3:0] dmk, input logic [31:0] dw);
        bus.if_req_i        = ir;
        bus.if_addr_i       = ia;
        bus.dm_req_i        = dr;
        bus.dm_addr_i       = da;
        bus.dm_write_mask_i = dmk;
        bus.dm_write_data_i = dw;
    endtask

    initial begin
        drv(1'b1, 32'h10, 1'b1, 32'h20, 4'h0, 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        // Reset held with both requests pending: everything quiet.
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        step();
        chk("first_gnt_dm", 32'(obs_dm_g), 32'd1);
        chk("first_gnt_if", 32'(obs_if_g), 32'd0);

        // Back-to-back fetch reads.
        drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        drv(1'b1, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        bus.if_addr_i = 32'h4;
        step();
        chk("fetch_rd0", obs_if_rd, 32'h0);
        bus.if_addr_i = 32'h8;
        step();
        chk("fetch_rd4", obs_if_rd, 32'h4);
        bus.if_req_i = 1'b0;
        step();
        chk("fetch_rd8", obs_if_rd, 32'h8);

        // Continuous contention: one forced fetch every MAXS+1 cycles.
        fetch_gnts = 0;
        drv(1'b1, 32'h40, 1'b1, 32'h80, 4'h0, 32'h0);
        for (int i = 0; i < 5 * (MAXS + 1); i++) step();
        chk("fetch_share", 32'(fetch_gnts), 32'd5 * 32'd4 / 32'(MAXS + 1) * 32'(MAXS + 1) / 32'd4);

        // Store then load the same word.
        drv(1'b0, 32'h0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        step();
        drv(1'b0, 32'h0, 1'b1, 32'h100, 4'h0, 32'h0);
        step();
        chk("no_rvalid_after_wr", 32'(obs_dm_rv), 32'd0);
        drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        chk("rd_after_wr_v", 32'(obs_dm_rv), 32'd1);
        chk("rd_after_wr_d", obs_dm_rd, 32'hDEADBEEF);

        // Reset lands while a fetch response is in flight.
        drv(1'b1, 32'h8, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        rst_n = 1'b0;
        drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        chk("dropped_rsp0", 32'(obs_if_rv), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("dropped_rsp1", 32'(obs_if_rv), 32'd0);
        step();
        chk("dropped_rsp2", 32'(obs_if_rv), 32'd0);

        // Contention counter: 10 contended cycles, then 5 fetch-only.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drv(1'b1, 32'hC0, 1'b1, 32'hE0, 4'h0, 32'h0);
        for (int i = 0; i < 10; i++) step();
        bus.dm_req_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
`ifdef MEM_ARB_PERF_EN
        chk("contention_10", obs_cnt, 32'd10);
`else
        chk("contention_off", obs_cnt, 32'd0);
`endif

        // Random traffic; requests stay stable until granted.
        drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        for (int c = 0; c < 400; c++) begin
            if (!bus.if_req_i || obs_if_g) begin
                bus.if_req_i  = 1'($urandom_range(0, 1));
                bus.if_addr_i = 32'($urandom_range(0, 255)) << 2;
            end
            if (!bus.dm_req_i || obs_dm_g) begin
                bus.dm_req_i        = 1'($urandom_range(0, 1));
                bus.dm_addr_i       = 32'($urandom_range(0, 255)) << 2;
                bus.dm_write_mask_i = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                bus.dm_write_data_i = $urandom;
            end
            rst_n = !(c >= 200 && c < 202);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
